wt_ptr_full_ctrl: RTL and testbench

Write-side controller for the asynchronous FIFO built on the dual-port RAM. It accepts producer write requests and drives the RAM write enable and write address. It maintains the binary and Gray write pointers, synchronises the read-domain Gray pointer, and generates full, almost-full and occupancy status, all in the write clock domain.

---
 rtl/wt_ptr_full_ctrl_if.sv | 35 +++
 rtl/wt_ptr_full_ctrl.sv | 65 ++++++
 tb/tb_wt_ptr_full_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wt_ptr_full_ctrl_if.sv
// Write-side bundle between the FIFO write controller and its producer / read-domain pointer.
// The wt_overflow member exists only when WT_OVERFLOW_FLAG_EN is defined.
interface wt_ptr_full_ctrl_if #(
    parameter int addr_width = 4
);
    logic                  wt_req;
    logic [addr_width:0]   rd_ptr_gray;
    logic                  wt_en_dp_ram;
    logic [addr_width-1:0] wt_addr;
    logic [addr_width:0]   wt_ptr_gray;
    logic                  wt_full;
    logic                  wt_almost_full;
    logic [addr_width:0]   wt_level;
`ifdef WT_OVERFLOW_FLAG_EN
    logic                  wt_overflow;

    modport master (
        output wt_req, rd_ptr_gray,
        input  wt_en_dp_ram, wt_addr, wt_ptr_gray, wt_full, wt_almost_full, wt_level, wt_overflow
    );
    modport slave (
        input  wt_req, rd_ptr_gray,
        output wt_en_dp_ram, wt_addr, wt_ptr_gray, wt_full, wt_almost_full, wt_level, wt_overflow
    );
`else
    modport master (
        output wt_req, rd_ptr_gray,
        input  wt_en_dp_ram, wt_addr, wt_ptr_gray, wt_full, wt_almost_full, wt_level
    );
    modport slave (
        input  wt_req, rd_ptr_gray,
        output wt_en_dp_ram, wt_addr, wt_ptr_gray, wt_full, wt_almost_full, wt_level
    );
`endif
endinterface

// File: rtl/wt_ptr_full_ctrl.sv
// Async-FIFO write-domain controller: binary/Gray write pointers, read-pointer sync, full/level flags.
// Optional sticky overflow flag enabled by defining WT_OVERFLOW_FLAG_EN.
module wt_ptr_full_ctrl #(
    parameter int addr_width   = 4,
    parameter int afull_thresh = 12
) (
    input  logic               wt_clk_dp_ram,
    input  logic               wt_rst_n_dp_ram_in,
    wt_ptr_full_ctrl_if.slave  wt_if
);
    localparam int            PW        = addr_width + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(afull_thresh);

    logic [PW-1:0] wt_bin, wt_bin_next, wt_gray_next, wt_gray_q;
    logic [PW-1:0] rq1, rq2, rd_bin, full_tgt, level;
    logic          accept, wt_full_q;

    assign accept       = wt_if.wt_req & ~wt_full_q;
    assign wt_bin_next  = wt_bin + PW'(accept);
    assign wt_gray_next = wt_bin_next ^ (wt_bin_next >> 1);
    // Write pointer is full when it sits one lap ahead of the read pointer.
    assign full_tgt     = {~rq2[PW-1:PW-2], rq2[PW-3:0]};

    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PW; i++) rd_bin[i] = ^(rq2 >> i);
    end

    assign level = wt_bin - rd_bin;

    always_ff @(posedge wt_clk_dp_ram or negedge wt_rst_n_dp_ram_in) begin
        if (!wt_rst_n_dp_ram_in) begin
            rq1       <= '0;
            rq2       <= '0;
            wt_bin    <= '0;
            wt_gray_q <= '0;
            wt_full_q <= 1'b0;
        end else begin
            rq1       <= wt_if.rd_ptr_gray;
            rq2       <= rq1;
            wt_bin    <= wt_bin_next;
            wt_gray_q <= wt_gray_next;
            wt_full_q <= (wt_gray_next == full_tgt);
        end
    end

    // The RAM write port is held in reset too, so no write may issue while reset is low.
    assign wt_if.wt_en_dp_ram   = accept & wt_rst_n_dp_ram_in;
    assign wt_if.wt_addr        = wt_bin[addr_width-1:0];
    assign wt_if.wt_ptr_gray    = wt_gray_q;
    assign wt_if.wt_full        = wt_full_q;
    assign wt_if.wt_level       = level;
    assign wt_if.wt_almost_full = (level >= AFULL_LVL);

`ifdef WT_OVERFLOW_FLAG_EN
    logic ovf_q;

    always_ff @(posedge wt_clk_dp_ram or negedge wt_rst_n_dp_ram_in) begin
        if (!wt_rst_n_dp_ram_in) ovf_q <= 1'b0;
        else                     ovf_q <= ovf_q | (wt_if.wt_req & wt_full_q);
    end

    assign wt_if.wt_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_wt_ptr_full_ctrl.sv
// Directed bench for wt_ptr_full_ctrl at addr_width=4, afull_thresh=12.
module tb_wt_ptr_full_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    wt_ptr_full_ctrl_if #(.addr_width(4)) wt_if ();

    wt_ptr_full_ctrl #(.addr_width(4), .afull_thresh(12)) dut (
        .wt_clk_dp_ram      (clk),
        .wt_rst_n_dp_ram_in (rst_n),
        .wt_if              (wt_if)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wt_if.wt_req      = 1'b0;
        wt_if.rd_ptr_gray = '0;
        rst_n             = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wt_if.wt_req      = 1'b1;
        wt_if.rd_ptr_gray = '0;
        rst_n             = 1'b0;
        step();
        step();
        n_checks++; if (wt_if.wt_en_dp_ram !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", wt_if.wt_en_dp_ram); end
        n_checks++; if (wt_if.wt_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", wt_if.wt_addr); end
        n_checks++; if (wt_if.wt_ptr_gray !== 5'd0) begin n_fail++; $display("FAIL reset_gray: got %b want 00000", wt_if.wt_ptr_gray); end
        n_checks++; if (wt_if.wt_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", wt_if.wt_full); end
        n_checks++; if (wt_if.wt_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", wt_if.wt_almost_full); end
        n_checks++; if (wt_if.wt_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", wt_if.wt_level); end
`ifdef WT_OVERFLOW_FLAG_EN
        n_checks++; if (wt_if.wt_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", wt_if.wt_overflow); end
`endif
        wt_if.wt_req = 1'b0;
        rst_n        = 1'b1;
        step();
    endtask

    task automatic test_fill();
        wt_if.rd_ptr_gray = '0;
        for (int i = 0; i < 16; i++) begin
            wt_if.wt_req = 1'b1;
            #1;
            n_checks++; if (wt_if.wt_en_dp_ram !== 1'b1) begin n_fail++; $display("FAIL fill_en[%0d]: got %b want 1", i, wt_if.wt_en_dp_ram); end
            n_checks++; if (wt_if.wt_addr !== 4'(i)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, wt_if.wt_addr, i); end
            n_checks++; if (wt_if.wt_level !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, wt_if.wt_level, i); end
            n_checks++; if (wt_if.wt_almost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, wt_if.wt_almost_full, (i >= 12)); end
            n_checks++; if (wt_if.wt_full !== 1'b0) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want 0", i, wt_if.wt_full); end
            @(posedge clk);
            #1;
        end
        // 17th cycle: request while full is blocked.
        #1;
        n_checks++; if (wt_if.wt_full !== 1'b1) begin n_fail++; $display("FAIL fill_full16: got %b want 1", wt_if.wt_full); end
        n_checks++; if (wt_if.wt_level !== 5'd16) begin n_fail++; $display("FAIL fill_level16: got %0d want 16", wt_if.wt_level); end
        n_checks++; if (wt_if.wt_ptr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_gray16: got %b want 11000", wt_if.wt_ptr_gray); end
        n_checks++; if (wt_if.wt_en_dp_ram !== 1'b0) begin n_fail++; $display("FAIL fill_en17: got %b want 0", wt_if.wt_en_dp_ram); end
        n_checks++; if (wt_if.wt_almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_afull16: got %b want 1", wt_if.wt_almost_full); end
        @(posedge clk);
        #1;
        wt_if.wt_req = 1'b0;
        #1;
        n_checks++; if (wt_if.wt_ptr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_hold_gray: got %b want 11000", wt_if.wt_ptr_gray); end
        n_checks++; if (wt_if.wt_level !== 5'd16) begin n_fail++; $display("FAIL fill_hold_level: got %0d want 16", wt_if.wt_level); end
    endtask

`ifdef WT_OVERFLOW_FLAG_EN
    task automatic test_overflow();
        n_checks++; if (wt_if.wt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", wt_if.wt_overflow); end
    endtask
`endif

    task automatic test_release();
        wt_if.rd_ptr_gray = 5'b00001;
        step();
        n_checks++; if (wt_if.wt_level !== 5'd16) begin n_fail++; $display("FAIL rel_level_e1: got %0d want 16", wt_if.wt_level); end
        n_checks++; if (wt_if.wt_full !== 1'b1) begin n_fail++; $display("FAIL rel_full_e1: got %b want 1", wt_if.wt_full); end
        step();
        n_checks++; if (wt_if.wt_level !== 5'd15) begin n_fail++; $display("FAIL rel_level_e2: got %0d want 15", wt_if.wt_level); end
        n_checks++; if (wt_if.wt_full !== 1'b1) begin n_fail++; $display("FAIL rel_full_e2: got %b want 1", wt_if.wt_full); end
        step();
        n_checks++; if (wt_if.wt_full !== 1'b0) begin n_fail++; $display("FAIL rel_full_e3: got %b want 0", wt_if.wt_full); end
        wt_if.wt_req = 1'b1;
        #1;
        n_checks++; if (wt_if.wt_en_dp_ram !== 1'b1) begin n_fail++; $display("FAIL rel_en: got %b want 1", wt_if.wt_en_dp_ram); end
        n_checks++; if (wt_if.wt_addr !== 4'd0) begin n_fail++; $display("FAIL rel_addr: got %0d want 0", wt_if.wt_addr); end
        @(posedge clk);
        #1;
        wt_if.wt_req = 1'b0;
        #1;
        n_checks++; if (wt_if.wt_full !== 1'b1) begin n_fail++; $display("FAIL rel_refull: got %b want 1", wt_if.wt_full); end
        n_checks++; if (wt_if.wt_level !== 5'd16) begin n_fail++; $display("FAIL rel_relevel: got %0d want 16", wt_if.wt_level); end
`ifdef WT_OVERFLOW_FLAG_EN
        n_checks++; if (wt_if.wt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", wt_if.wt_overflow); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wt_if.wt_req = 1'b1;
            step();
        end
        n_checks++; if (wt_if.wt_level !== 5'd7) begin n_fail++; $display("FAIL mid_level7: got %0d want 7", wt_if.wt_level); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (wt_if.wt_en_dp_ram !== 1'b0) begin n_fail++; $display("FAIL mid_en: got %b want 0", wt_if.wt_en_dp_ram); end
        n_checks++; if (wt_if.wt_addr !== 4'd0) begin n_fail++; $display("FAIL mid_addr: got %0d want 0", wt_if.wt_addr); end
        n_checks++; if (wt_if.wt_ptr_gray !== 5'd0) begin n_fail++; $display("FAIL mid_gray: got %b want 00000", wt_if.wt_ptr_gray); end
        n_checks++; if (wt_if.wt_level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", wt_if.wt_level); end
        n_checks++; if (wt_if.wt_full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", wt_if.wt_full); end
`ifdef WT_OVERFLOW_FLAG_EN
        n_checks++; if (wt_if.wt_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b want 0", wt_if.wt_overflow); end
`endif
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (wt_if.wt_en_dp_ram !== 1'b1) begin n_fail++; $display("FAIL mid_post_en: got %b want 1", wt_if.wt_en_dp_ram); end
        n_checks++; if (wt_if.wt_addr !== 4'd0) begin n_fail++; $display("FAIL mid_post_addr: got %0d want 0", wt_if.wt_addr); end
        @(posedge clk);
        #1;
        wt_if.wt_req = 1'b0;
        #1;
        n_checks++; if (wt_if.wt_addr !== 4'd1) begin n_fail++; $display("FAIL mid_post_addr1: got %0d want 1", wt_if.wt_addr); end
        n_checks++; if (wt_if.wt_ptr_gray !== 5'b00001) begin n_fail++; $display("FAIL mid_post_gray: got %b want 00001", wt_if.wt_ptr_gray); end
    endtask

    task automatic test_wrap();
        int full_seen = 0;
        int addr_wraps = 0;
        logic [4:0] rd;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rd = (i >= 4) ? 5'(i - 4) : 5'd0;
            wt_if.rd_ptr_gray = to_gray(rd);
            wt_if.wt_req      = 1'b1;
            #1;
            n_checks++; if (wt_if.wt_en_dp_ram !== 1'b1 || wt_if.wt_addr !== 4'(i % 16)) begin
                n_fail++; $display("FAIL wrap_wr[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, wt_if.wt_en_dp_ram, wt_if.wt_addr, i % 16); end
            n_checks++; if (wt_if.wt_level !== 5'((i < 6) ? i : 6)) begin
                n_fail++; $display("FAIL wrap_level[%0d]: got %0d want %0d", i, wt_if.wt_level, (i < 6) ? i : 6); end
            if (i == 31) begin
                n_checks++; if (wt_if.wt_ptr_gray !== 5'b10000) begin n_fail++; $display("FAIL wrap_gray31: got %b want 10000", wt_if.wt_ptr_gray); end
            end
            if (i == 32) begin
                n_checks++; if (wt_if.wt_ptr_gray !== 5'b00000) begin n_fail++; $display("FAIL wrap_gray32: got %b want 00000", wt_if.wt_ptr_gray); end
            end
            if (i > 0 && i % 16 == 0 && wt_if.wt_addr === 4'd0) addr_wraps++;
            if (wt_if.wt_full !== 1'b0) full_seen++;
            @(posedge clk);
            #1;
        end
        wt_if.wt_req = 1'b0;
        n_checks++; if (full_seen != 0) begin n_fail++; $display("FAIL wrap_full: got %0d full cycles want 0", full_seen); end
        n_checks++; if (addr_wraps != 2) begin n_fail++; $display("FAIL wrap_count: got %0d wraps want 2", addr_wraps); end
    endtask

    initial begin
        wt_if.wt_req      = 1'b0;
        wt_if.rd_ptr_gray = '0;
        test_reset();
        test_fill();
`ifdef WT_OVERFLOW_FLAG_EN
        test_overflow();
`endif
        test_release();
        test_mid_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
